// File: rtl/wb_port_arbiter.sv
// Writeback-port arbiter: shares the register-file write port between the in-order
// WB stage and a buffered MDU result stream, with a starvation-driven one-cycle stall.
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        stall_o,
  output logic        wb_sel,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [3:0]  LIMIT    = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PIPE,
    GNT_MDU
  } grant_e;

  logic [4:0]    mem_rd   [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [3:0]    age;

  logic          not_empty;
  logic          push;
  logic          pop;
  grant_e        grant;
  logic [4:0]    sel_rd;
  logic [31:0]   sel_data;

  assign not_empty = (count != '0);
  assign mdu_ready = (count != FULL_CNT);
  // Built from registered count/age only, so the pipeline freeze has no input-to-output path.
  assign stall_o   = not_empty && (age >= LIMIT);
  assign push      = mdu_valid && mdu_ready;
  assign pop       = (grant == GNT_MDU);

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    grant    = GNT_NONE;
    sel_rd   = '0;
    sel_data = '0;
    if (stall_o) begin
      grant = GNT_MDU;
    end else if (pipe_valid) begin
      grant = GNT_PIPE;
    end else if (not_empty) begin
      grant = GNT_MDU;
    end
    case (grant)
      GNT_PIPE: begin
        sel_rd   = pipe_rd;
        sel_data = pipe_data;
      end
      GNT_MDU: begin
        sel_rd   = mem_rd[rd_ptr];
        sel_data = mem_data[rd_ptr];
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      age    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
      // A head that is present and not popped has lost arbitration this cycle.
      if (!not_empty || pop) begin
        age <= '0;
      end else if (age != 4'hF) begin
        age <= age + 4'd1;
      end
    end
  end

  // NOTE: FIFO storage is deliberately not reset; count and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wr_ptr]   <= mdu_rd;
      mem_data[wr_ptr] <= mdu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_en   <= 1'b0;
      wb_sel  <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else begin
      // Writes to x0 still consume the grant but never reach the register file.
      wb_en <= (grant != GNT_NONE) && (sel_rd != 5'd0);
      if (grant != GNT_NONE) begin
        wb_sel  <= (grant == GNT_MDU);
        wb_rd   <= sel_rd;
        wb_data <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: queue-based reference model feeding a
// scoreboard, a negedge monitor, directed scenarios and a randomized run.
module tb_wb_port_arbiter;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk;
  logic        rst_n;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        stall_o;
  logic        wb_sel;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .stall_o(stall_o), .wb_sel(wb_sel), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } mdu_t;

  typedef struct {
    int unsigned cyc;
    logic        sel;
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  int          tests = 0;
  int          fails = 0;
  mdu_t        mq[$];
  wr_t         sb[$];
  int          mdu_log[$];
  int          m_wait  = 0;
  logic        exp_sel = 1'b0;
  int unsigned cyc     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic model_stall();
    return (mq.size() != 0) && (m_wait >= STARVE_LIMIT);
  endfunction

  task automatic model_clear();
    mq.delete();
    sb.delete();
    m_wait  = 0;
    exp_sel = 1'b0;
  endtask

  // Reference model: arbitration rules applied to a plain queue of pending MDU results.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        model_clear();
      end else begin
        logic st;
        logic do_push;
        mdu_t e;
        wr_t  w;
        cyc++;
        st      = model_stall();
        do_push = mdu_valid && (mq.size() < DEPTH);
        if (st || (!pipe_valid && mq.size() != 0)) begin
          e       = mq.pop_front();
          m_wait  = 0;
          exp_sel = 1'b1;
          if (e.rd != 0) begin
            w = '{cyc: cyc, sel: 1'b1, rd: e.rd, data: e.data};
            sb.push_back(w);
          end
        end else begin
          if (pipe_valid) begin
            exp_sel = 1'b0;
            if (pipe_rd != 0) begin
              w = '{cyc: cyc, sel: 1'b0, rd: pipe_rd, data: pipe_data};
              sb.push_back(w);
            end
          end
          if (mq.size() != 0 && m_wait < 15) m_wait++;
        end
        if (do_push) begin
          e = '{rd: mdu_rd, data: mdu_data};
          mq.push_back(e);
        end
      end
    end
  end

  // Monitor: compares what the DUT presents against the model's current view.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        logic exp_en;
        wr_t  w;
        check("stall_o", stall_o, model_stall());
        check("mdu_ready", mdu_ready, mq.size() < DEPTH);
        check("wb_sel_hold", wb_sel, exp_sel);
        exp_en = (sb.size() != 0) && (sb[0].cyc <= cyc);
        check("wb_en", wb_en, exp_en);
        if (wb_en && wb_sel) mdu_log.push_back(int'(wb_rd));
        if (exp_en) begin
          w = sb.pop_front();
          if (wb_en) begin
            check("wb_latency", cyc, w.cyc);
            check("wb_sel", wb_sel, w.sel);
            check("wb_rd", wb_rd, w.rd);
            check("wb_data", wb_data, w.data);
          end
        end
      end
    end
  end

  task automatic step(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    pipe_valid = pv;
    pipe_rd    = prd;
    pipe_data  = pd;
    mdu_valid  = mv;
    mdu_rd     = mrd;
    mdu_data   = md;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wb_en"}, wb_en, 1'b0);
    check({tag, "_wb_sel"}, wb_sel, 1'b0);
    check({tag, "_wb_rd"}, wb_rd, 5'd0);
    check({tag, "_wb_data"}, wb_data, 32'd0);
    check({tag, "_stall"}, stall_o, 1'b0);
    check({tag, "_ready"}, mdu_ready, 1'b1);
  endtask

  initial begin
    logic        hold;
    logic        pv;
    logic [4:0]  prd;
    logic [31:0] pd;
    int          idx;
    int          low;
    int          rds[3];

    // Reset held with random inputs.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step($urandom_range(0, 1), 5'($urandom), $urandom, $urandom_range(0, 1), 5'($urandom), $urandom);
      check_reset_outputs("reset_hold");
    end
    pipe_valid = 1'b0;
    mdu_valid  = 1'b0;
    rst_n      = 1'b1;
    idle(2);

    // Idle drain: push at cycle 0, pop at cycle 1, write visible at cycle 2.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    check("drain_stall_c1", stall_o, 1'b0);
    idle(1);
    check("drain_wb_en", wb_en, 1'b1);
    check("drain_wb_sel", wb_sel, 1'b1);
    check("drain_wb_rd", wb_rd, 5'd5);
    check("drain_wb_data", wb_data, 32'hDEADBEEF);
    check("drain_stall_c2", stall_o, 1'b0);
    idle(3);

    // Starvation: continuous pipeline traffic, one MDU result forced out by a stall in cycle 5.
    step(1'b1, 5'd3, 32'h11111111, 1'b1, 5'd7, 32'h22222222);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("starve_nostall_c%0d", k), stall_o, 1'b0);
      if (k == 3) begin
        check("prio_wb_sel", wb_sel, 1'b0);
        check("prio_wb_rd", wb_rd, 5'd3);
      end
      step(1'b1, 5'd3, 32'h11111111, 1'b0, 5'd0, 32'd0);
    end
    check("starve_stall_c5", stall_o, 1'b1);
    step(1'b1, 5'd3, 32'h11111111, 1'b0, 5'd0, 32'd0);
    check("starve_c6_sel", wb_sel, 1'b1);
    check("starve_c6_rd", wb_rd, 5'd7);
    check("starve_c6_stall", stall_o, 1'b0);
    step(1'b1, 5'd3, 32'h11111111, 1'b0, 5'd0, 32'd0);
    check("starve_c7_sel", wb_sel, 1'b0);
    check("starve_c7_rd", wb_rd, 5'd3);
    idle(3);

    // Full / backpressure: three offers into a two-entry FIFO under constant pipeline load.
    rds = '{8, 9, 10};
    idx = 0;
    low = 0;
    mdu_log.delete();
    for (int c = 0; c < 20; c++) begin
      logic acc;
      acc = (idx < 3) && mdu_ready;
      if (idx < 3 && !mdu_ready) low++;
      step(1'b1, 5'd3, 32'h11111111, idx < 3, 5'(rds[idx % 3]), 32'hA0000000 + 32'(idx));
      if (acc) idx++;
    end
    idle(4);
    check("full_accepted", idx, 3);
    check("full_ready_low_cycles", low, 4);
    check("full_order_count", mdu_log.size(), 3);
    for (int i = 0; i < 3 && i < mdu_log.size(); i++)
      check($sformatf("full_order_%0d", i), mdu_log[i], rds[i]);
    idle(2);

    // x0: grant consumed, no write.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55555555);
    idle(1);
    check("x0_wb_en", wb_en, 1'b0);
    check("x0_wb_sel", wb_sel, 1'b1);
    idle(2);

    // Push and pop together at count 1: new head starts at age 0, stalls four lost cycles later.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h66666666);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'hBBBBBBBB);
    check("simul_ready", mdu_ready, 1'b1);
    for (int k = 2; k <= 5; k++) begin
      check($sformatf("simul_nostall_c%0d", k), stall_o, 1'b0);
      step(1'b1, 5'd4, 32'h44444444, 1'b0, 5'd0, 32'd0);
    end
    check("simul_stall_c6", stall_o, 1'b1);
    step(1'b1, 5'd4, 32'h44444444, 1'b0, 5'd0, 32'd0);
    check("simul_c7_rd", wb_rd, 5'd11);
    idle(3);

    // Asynchronous reset mid-clock with two entries buffered.
    mdu_log.delete();
    step(1'b1, 5'd1, 32'h1, 1'b1, 5'd12, 32'hC0C0C0C0);
    step(1'b1, 5'd1, 32'h1, 1'b1, 5'd13, 32'hD0D0D0D0);
    pipe_valid = 1'b0;
    mdu_valid  = 1'b0;
    check("areset_full_before", mdu_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    check_reset_outputs("areset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check($sformatf("areset_no_write_%0d", i), wb_en, 1'b0);
    end
    check("areset_no_mdu_log", mdu_log.size(), 0);

    // Randomized traffic with varying pipeline density; WB stage holds its result after a stall.
    hold = 1'b0;
    pv   = 1'b0;
    prd  = '0;
    pd   = '0;
    for (int i = 0; i < 3000; i++) begin
      int phase;
      phase = (i / 300) % 3;
      if (!hold) begin
        case (phase)
          0:       pv = ($urandom_range(0, 3) == 0);
          1:       pv = ($urandom_range(0, 3) != 0);
          default: pv = 1'b1;
        endcase
        prd = 5'($urandom);
        pd  = $urandom;
      end
      hold = stall_o;
      step(pv, prd, pd, $urandom_range(0, 1), 5'($urandom), $urandom);
    end
    idle(30);
    check("final_scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file writeback port, and the 2:1 writeback select mux in front of it, between two requesters.
- Requester 0: in-order pipeline WB stage. Requester 1: a multi-cycle multiply/divide unit (MDU) whose results complete out of band.
- MDU results are buffered in a small FIFO and drained into idle WB slots. A starvation guard stalls the pipeline for one cycle when an MDU result has waited too long.
- Sits between the WB stage / MDU and the register file; drives the mux select and the register-file write enable.

Parameters:
- DEPTH, 2, MDU result FIFO entries (power of 2, >=2)
- STARVE_LIMIT, 4, cycles an MDU head entry may lose arbitration before a forced stall (1..15)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- pipe_valid  in  1  WB stage holds a result this cycle
- pipe_rd  in  5  destination register, pipeline
- pipe_data  in  32  result data, pipeline
- mdu_valid  in  1  MDU offers a result
- mdu_ready  out  1  FIFO can accept; equals !full
- mdu_rd  in  5  destination register, MDU
- mdu_data  in  32  result data, MDU
- stall_o  out  1  freeze pipeline (IF..WB hold) this cycle
- wb_sel  out  1  writeback mux select: 0 = pipeline, 1 = MDU
- wb_en  out  1  register-file write enable
- wb_rd  out  5  register-file write address
- wb_data  out  32  register-file write data

Behaviour:
- Reset (async, rst_n=0): FIFO count=0, pointers=0, age=0; wb_en=0, wb_sel=0, wb_rd=0, wb_data=0, stall_o=0; mdu_ready=1. Reset mid-operation discards all buffered MDU results.
- Push: accepted on a rising edge when mdu_valid && mdu_ready. Entry becomes eligible the following cycle; there is no same-cycle bypass.
- mdu_ready = (count != DEPTH). A push is refused when full, even if a pop occurs that cycle.
- Age counter: tracks the head entry.
  - Clears to 0 when the FIFO is empty or on a pop.
  - Otherwise increments each cycle the head is present and not granted; saturates at 15.
- stall_o = (count != 0) && (age >= STARVE_LIMIT). Derived only from registers, so it has no combinational path from inputs.
- Grant per cycle, in priority order:
  1. stall_o=1: grant MDU head; pipe_valid is ignored, because the pipeline re-presents its result next cycle.
  2. pipe_valid=1: grant pipeline.
  3. count != 0: grant MDU head (pop).
  4. Otherwise: no grant.
- Output latency: exactly 1 cycle. wb_* outputs are registered from the grant cycle.
  - wb_sel = 1 if MDU was granted, else 0. It holds its last value when there is no grant.
  - wb_rd and wb_data take the granted requester's rd and data.
  - wb_en = 1 if a grant occurred and the granted rd != 0. A write to x0 still consumes the grant/pop but produces wb_en=0.
- Simultaneous push and pop: count unchanged, pointers both advance, wrap modulo DEPTH.
- Pop when count == 1 with a simultaneous push: the new entry becomes head with age=0.
- stall_o is high for exactly one cycle per starved entry. That entry pops in the stall cycle, so age clears. The next entry starts at age 0.
- Pipeline contract: while stall_o=1, the WB stage holds pipe_valid/pipe_rd/pipe_data stable into the next cycle.

Test Plan:
- Reset: hold rst_n=0 with random inputs. Required: wb_en=0, wb_sel=0, wb_rd=0, wb_data=0, stall_o=0, mdu_ready=1. Assert rst_n=0 asynchronously mid-clock with 2 entries buffered; required: mdu_ready=1 immediately, and no MDU write ever appears afterwards.
- Idle drain: pipe_valid=0; push MDU rd=5, data=0xDEADBEEF at cycle 0. Required: pop at cycle 1; at cycle 2 wb_en=1, wb_sel=1, wb_rd=5, wb_data=0xDEADBEEF; stall_o never asserted.
- Starvation: pipe_valid=1 continuously (rd=3, data=0x11111111); push MDU rd=7, data=0x22222222 at cycle 0. Required: age 0..3 over cycles 1..4; stall_o=1 only in cycle 5; cycle 6 outputs wb_sel=1, wb_rd=7; cycle 7 returns to wb_sel=0, wb_rd=3.
- Full/backpressure: pipe_valid=1 continuously; mdu_valid=1 with 3 offers (rd=8,9,10). Required: 2 accepted and mdu_ready=0 on the third until the first forced pop; writeback order rd 8 then 9 then 10, none lost or duplicated.
- x0 and simultaneity: push MDU rd=0 while idle → grant consumed with wb_en=0 and count returns to 0. Push and pop in the same cycle at count=1 → count stays 1 and the new head's age restarts at 0.
- Pipeline priority: pipe_valid=1 with rd=4 and FIFO head age=1. Required: pipeline granted (wb_sel=0, wb_rd=4 next cycle); FIFO count unchanged; age increments to 2.
